// File: rtl/sap1_step_sequencer.sv
// SAP-1 microstep sequencer / run controller: owns IR and step counter, gates datapath updates.
// Optional performance counters are enabled with `define SAP1_SEQ_PERF_COUNTERS_EN.
module sap1_step_sequencer #(
  parameter int INSTRUCTION_WIDTH = 4,
  parameter int OPERAND_WIDTH     = 4,
  parameter int INSTRUCTION_STEPS = 8,
  parameter int PERF_WIDTH        = 16,
  localparam int STEP_WIDTH       = $clog2(INSTRUCTION_STEPS)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_run,
  input  logic                                 i_step_req,
  input  logic                                 i_resume,
  input  logic [INSTRUCTION_WIDTH+OPERAND_WIDTH-1:0] i_bus,
  input  logic                                 i_instrregi,
  input  logic                                 i_adv,
  input  logic                                 i_halt,
`ifdef SAP1_SEQ_PERF_COUNTERS_EN
  input  logic                                 i_perf_clr,
  output logic [PERF_WIDTH-1:0]                o_cycle_count,
  output logic [PERF_WIDTH-1:0]                o_retire_count,
`endif
  output logic [STEP_WIDTH-1:0]                o_step,
  output logic [INSTRUCTION_WIDTH-1:0]         o_instruction,
  output logic [OPERAND_WIDTH-1:0]             o_operand,
  output logic                                 o_clk_en,
  output logic                                 o_halted,
  output logic                                 o_step_ack,
  output logic [1:0]                           o_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SINGLE = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

  state_t                                   state, state_next;
  logic [STEP_WIDTH-1:0]                    step, step_next;
  logic [INSTRUCTION_WIDTH+OPERAND_WIDTH-1:0] ir;
  logic                                     ack, ack_next;
  logic                                     clk_en;
  logic                                     retire;

  // Enable depends on state alone so the datapath never sees input glitches.
  assign clk_en = (state == RUN) || (state == SINGLE);
  assign retire = clk_en && !i_halt && (i_adv || (step == LAST_STEP));

  always_comb begin
    state_next = state;
    step_next  = step;
    ack_next   = 1'b0;
    case (state)
      IDLE: begin
        step_next = '0;
        if (i_run)           state_next = RUN;
        else if (i_step_req) state_next = SINGLE;
      end
      RUN, SINGLE: begin
        if (i_halt) begin
          state_next = HALTED;
        end else if (retire) begin
          step_next  = '0;
          state_next = (state == RUN && i_run) ? RUN : IDLE;
          ack_next   = (state == SINGLE);
        end else begin
          step_next = step + STEP_WIDTH'(1);
        end
      end
      HALTED: begin
        if (i_resume) begin
          state_next = IDLE;
          step_next  = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      step  <= '0;
      ir    <= '0;
      ack   <= 1'b0;
    end else begin
      state <= state_next;
      step  <= step_next;
      ack   <= ack_next;
      if (clk_en && i_instrregi) ir <= i_bus;
    end
  end

`ifdef SAP1_SEQ_PERF_COUNTERS_EN
  logic [PERF_WIDTH-1:0] cycle_count, retire_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycle_count  <= '0;
      retire_count <= '0;
    end else if (i_perf_clr) begin
      cycle_count  <= '0;
      retire_count <= '0;
    end else begin
      if (clk_en && cycle_count != '1)  cycle_count  <= cycle_count + PERF_WIDTH'(1);
      if (retire && retire_count != '1) retire_count <= retire_count + PERF_WIDTH'(1);
    end
  end

  assign o_cycle_count  = cycle_count;
  assign o_retire_count = retire_count;
`endif

  assign o_step        = step;
  assign o_instruction = ir[INSTRUCTION_WIDTH+OPERAND_WIDTH-1:OPERAND_WIDTH];
  assign o_operand     = ir[OPERAND_WIDTH-1:0];
  assign o_clk_en      = clk_en;
  assign o_halted      = (state == HALTED);
  assign o_step_ack    = ack;
  assign o_state       = state;

endmodule

// File: tb/tb_sap1_step_sequencer.sv
// Scoreboard bench for sap1_step_sequencer: expected outputs are queued per driven cycle.
module tb_sap1_step_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0, step_req = 1'b0, resume = 1'b0;
  logic [7:0] bus = '0;
  logic       instrregi = 1'b0, adv = 1'b0, halt = 1'b0;
  logic [2:0] step;
  logic [3:0] instruction, operand;
  logic       clk_en, halted, step_ack;
  logic [1:0] state;
`ifdef SAP1_SEQ_PERF_COUNTERS_EN
  logic        perf_clr = 1'b0;
  logic [15:0] cycle_count, retire_count;
`endif

  sap1_step_sequencer #(
    .INSTRUCTION_WIDTH(4),
    .OPERAND_WIDTH(4),
    .INSTRUCTION_STEPS(8),
    .PERF_WIDTH(16)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_run(run),
    .i_step_req(step_req),
    .i_resume(resume),
    .i_bus(bus),
    .i_instrregi(instrregi),
    .i_adv(adv),
    .i_halt(halt),
`ifdef SAP1_SEQ_PERF_COUNTERS_EN
    .i_perf_clr(perf_clr),
    .o_cycle_count(cycle_count),
    .o_retire_count(retire_count),
`endif
    .o_step(step),
    .o_instruction(instruction),
    .o_operand(operand),
    .o_clk_en(clk_en),
    .o_halted(halted),
    .o_step_ack(step_ack),
    .o_state(state)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_SINGLE = 2'd2, S_HALTED = 2'd3;

  typedef struct {
    logic [1:0] st;
    logic [2:0] step;
    logic       en;
    logic       hlt;
    logic       ack;
    logic [3:0] ins;
    logic [3:0] opr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  logic [3:0] cur_ins = '0, cur_opr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic exp_push(input logic [1:0] st, input int stp, input logic en,
                          input logic hlt, input logic ack);
    exp_t e;
    e.st = st; e.step = 3'(stp); e.en = en; e.hlt = hlt; e.ack = ack;
    e.ins = cur_ins; e.opr = cur_opr;
    q.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
      return;
    end
    e = q.pop_front();
    check("state", 32'(state), 32'(e.st));
    check("step", 32'(step), 32'(e.step));
    check("clk_en", 32'(clk_en), 32'(e.en));
    check("halted", 32'(halted), 32'(e.hlt));
    check("step_ack", 32'(step_ack), 32'(e.ack));
    check("instruction", 32'(instruction), 32'(e.ins));
    check("operand", 32'(operand), 32'(e.opr));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic reset_expect();
    cur_ins = '0; cur_opr = '0;
    exp_push(S_IDLE, 0, 1'b0, 1'b0, 1'b0);
    compare_front();
`ifdef SAP1_SEQ_PERF_COUNTERS_EN
    check("cycle_count_rst", 32'(cycle_count), 32'd0);
    check("retire_count_rst", 32'(retire_count), 32'd0);
`endif
  endtask

  initial begin
    // Reset values while held in reset
    #12;
    reset_expect();
    rst_n = 1'b1;
    exp_push(S_IDLE, 0, 1'b0, 1'b0, 1'b0);
    tick();

    // Free run, ADV at step 4; IR load at step 1 of the first instruction
    run = 1'b1;
    exp_push(S_RUN, 0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int unsigned n = 0; n < 3; n++) begin
      if (n == 2) run = 1'b0;
      for (int unsigned s = 0; s < 5; s++) begin
        adv = (s == 4);
        instrregi = (n == 0 && s == 1);
        bus = instrregi ? 8'h2A : 8'($urandom);
        if (instrregi) begin cur_ins = 4'h2; cur_opr = 4'hA; end
        if (s == 4 && n == 2) exp_push(S_IDLE, 0, 1'b0, 1'b0, 1'b0);
        else exp_push(S_RUN, (s == 4) ? 0 : int'(s) + 1, 1'b1, 1'b0, 1'b0);
        tick();
      end
    end
    adv = 1'b0; instrregi = 1'b0;

    // Single step, ADV at step 3, second request mid-instruction ignored
    step_req = 1'b1;
    exp_push(S_SINGLE, 0, 1'b1, 1'b0, 1'b0);
    tick();
    step_req = 1'b0;
    for (int unsigned s = 0; s < 4; s++) begin
      adv = (s == 3);
      step_req = (s == 1);
      if (s == 3) exp_push(S_IDLE, 0, 1'b0, 1'b0, 1'b1);
      else exp_push(S_SINGLE, int'(s) + 1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    adv = 1'b0; step_req = 1'b0;
    exp_push(S_IDLE, 0, 1'b0, 1'b0, 1'b0);
    tick();

    // Halt at step 2 in RUN, first with HLT alone, then HLT+ADV
    run = 1'b1;
    for (int unsigned pass = 0; pass < 2; pass++) begin
      exp_push(S_RUN, 0, 1'b1, 1'b0, 1'b0);
      tick();
      for (int unsigned s = 0; s < 2; s++) begin
        exp_push(S_RUN, int'(s) + 1, 1'b1, 1'b0, 1'b0);
        tick();
      end
      halt = 1'b1; adv = (pass == 1);
      exp_push(S_HALTED, 2, 1'b0, 1'b1, 1'b0);
      tick();
      halt = 1'b0; adv = 1'b1; instrregi = 1'b1; step_req = 1'b1; bus = 8'hFF;
      exp_push(S_HALTED, 2, 1'b0, 1'b1, 1'b0);
      tick();
      adv = 1'b0; instrregi = 1'b0; step_req = 1'b0;
      for (int unsigned k = 0; k < 2; k++) begin
        exp_push(S_HALTED, 2, 1'b0, 1'b1, 1'b0);
        tick();
      end
      if (pass == 1) run = 1'b0;
      resume = 1'b1;
      exp_push(S_IDLE, 0, 1'b0, 1'b0, 1'b0);
      tick();
      resume = 1'b0;
    end

    // Resume outside HALTED has no effect
    resume = 1'b1;
    exp_push(S_IDLE, 0, 1'b0, 1'b0, 1'b0);
    tick();
    resume = 1'b0;

    // Halt during SINGLE: no acknowledge
    step_req = 1'b1;
    exp_push(S_SINGLE, 0, 1'b1, 1'b0, 1'b0);
    tick();
    step_req = 1'b0; halt = 1'b1;
    exp_push(S_HALTED, 0, 1'b0, 1'b1, 1'b0);
    tick();
    halt = 1'b0; resume = 1'b1;
    exp_push(S_IDLE, 0, 1'b0, 1'b0, 1'b0);
    tick();
    resume = 1'b0;
    exp_push(S_IDLE, 0, 1'b0, 1'b0, 1'b0);
    tick();

    // Forced wrap without ADV; run dropped at step 3 of the second instruction
    run = 1'b1;
    exp_push(S_RUN, 0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int unsigned n = 0; n < 2; n++) begin
      for (int unsigned s = 0; s < 8; s++) begin
        if (n == 1 && s == 3) run = 1'b0;
        if (n == 1 && s == 7) exp_push(S_IDLE, 0, 1'b0, 1'b0, 1'b0);
        else exp_push(S_RUN, (int'(s) + 1) % 8, 1'b1, 1'b0, 1'b0);
        tick();
      end
    end

    // Asynchronous reset mid-instruction at step 5
    run = 1'b1;
    exp_push(S_RUN, 0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int unsigned s = 0; s < 5; s++) begin
      exp_push(S_RUN, int'(s) + 1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    reset_expect();
    run = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_push(S_IDLE, 0, 1'b0, 1'b0, 1'b0);
    tick();

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sap1_step_sequencer.md
Name: sap1_step_sequencer

Overview:
- Microstep sequencer and run controller for the SAP-1 control path.
- Owns the instruction register and the microstep counter that feed the combinational instruction decoder.
- Consumes the decoder's advance and halt strobes.
- Produces a datapath clock-enable that gates every register update, supporting free-run, single-instruction stepping, and halt/resume.

Parameters:
- INSTRUCTION_WIDTH, 4, opcode field width (upper bits of bus word)
- OPERAND_WIDTH, 4, operand field width (lower bits of bus word)
- INSTRUCTION_STEPS, 8, microsteps per instruction slot; STEP_WIDTH = $clog2(INSTRUCTION_STEPS) (localparam)
- PERF_WIDTH, 16, width of performance counters (used only with the optional feature)

Ports:
- i_clk  in  1  system clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_run  in  1  level; 1 = free-run request
- i_step_req  in  1  one-cycle pulse; execute exactly one instruction
- i_resume  in  1  one-cycle pulse; leave HALTED
- i_bus  in  INSTRUCTION_WIDTH+OPERAND_WIDTH  shared data bus
- i_instrregi  in  1  decoder II strobe; load IR from i_bus
- i_adv  in  1  decoder ADV strobe; end of current instruction
- i_halt  in  1  decoder HLT strobe
- o_step  out  STEP_WIDTH  current microstep, to decoder
- o_instruction  out  INSTRUCTION_WIDTH  IR opcode field, to decoder
- o_operand  out  OPERAND_WIDTH  IR operand field, to bus driver
- o_clk_en  out  1  datapath update enable this cycle
- o_halted  out  1  state == HALTED
- o_step_ack  out  1  one-cycle pulse; single-step instruction completed
- o_state  out  2  IDLE=0, RUN=1, SINGLE=2, HALTED=3

Behaviour:
- Reset (async, any time, including mid-instruction) drives:
  - state IDLE, o_step 0, IR 0, o_clk_en 0, o_step_ack 0, o_halted 0.
  - Release is sampled on the next i_clk edge.
- o_clk_en is a Moore decode of state: 1 in RUN and SINGLE, 0 in IDLE and HALTED. It is never a function of inputs.
- i_instrregi, i_adv and i_halt are acted on only in a cycle where o_clk_en=1; otherwise they are ignored.
- IR load: when o_clk_en & i_instrregi, IR <= i_bus at the edge. The new value is visible the next cycle. IR is otherwise held, including across HALTED and IDLE.
- Step counter, applied only when o_clk_en=1. Priority, highest first:
  1. i_halt: step held, next state HALTED.
  2. i_adv: step <= 0, instruction retired.
  3. o_step == INSTRUCTION_STEPS-1: step <= 0, instruction retired (forced wrap; a missing ADV never hangs the sequencer).
  4. Otherwise: step <= step+1.
- State IDLE:
  - i_run=1 -> RUN.
  - Else i_step_req -> SINGLE.
  - If both are asserted, RUN wins.
  - o_step is always 0 in IDLE.
- State RUN:
  - Retire with i_run=1 -> stay in RUN.
  - Retire with i_run=0 -> IDLE. Deasserting i_run takes effect only at an instruction boundary; the current instruction always completes.
  - i_step_req is ignored.
- State SINGLE:
  - Runs exactly one instruction, then goes to IDLE.
  - o_step_ack pulses high for the one cycle after retire (first IDLE cycle).
  - i_run and i_step_req are ignored until back in IDLE.
- State HALTED:
  - Entered from RUN or SINGLE on i_halt. o_halted=1 and o_clk_en=0.
  - i_resume -> IDLE with step <= 0, so the next instruction fetches from the already-advanced program counter.
  - A halt hit in SINGLE does not produce o_step_ack.
  - i_run, i_step_req and a reset-free hold have no effect.
- Simultaneous i_halt and i_adv: halt wins, no retire.
- i_resume outside HALTED: ignored.
- Latency: the first microstep executes in the cycle after entering RUN/SINGLE. An instruction that asserts ADV at step N occupies N+1 enabled cycles.

Optional Feature:
- Macro: SAP1_SEQ_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs o_cycle_count[PERF_WIDTH] and o_retire_count[PERF_WIDTH].
  - o_cycle_count increments on every cycle with o_clk_en=1.
  - o_retire_count increments on every retire (ADV or forced wrap).
  - Both saturate at all-ones (no wrap), reset to 0 asynchronously, and hold in IDLE and HALTED.
  - Adds input i_perf_clr (synchronous pulse), which zeroes both counters. If it coincides with an increment, the clear wins.
- Undefined: none of these ports or registers exist. All other behaviour is identical.

Test Plan:
- Run, LDA-style program: reset, i_run=1; decoder asserts ADV at step 4 each instruction -> o_step sequence 0,1,2,3,4,0 repeating; o_state=1; o_clk_en=1 throughout.
- IR load: at step 1 drive i_bus=8'h2A with i_instrregi=1 -> next cycle o_instruction=4'h2, o_operand=4'hA; IR held while i_bus changes.
- Single step: IDLE, pulse i_step_req, ADV at step 3 -> exactly 4 enabled cycles, o_step_ack high 1 cycle, back to o_state=0 with o_step=0; second i_step_req during SINGLE ignored.
- Halt/resume: RUN, HLT at step 2 -> o_halted=1, o_clk_en=0, o_step held at 2 indefinitely; i_halt and i_adv together give the same result; pulse i_resume -> o_state=0, o_step=0.
- Forced wrap and run drop: no ADV ever -> o_step 0..7 then 0; drop i_run at step 3 -> continues to 7, then IDLE.
- Async reset mid-instruction at step 5 in RUN -> all outputs go to reset values immediately without a clock edge; with the feature enabled, counters read 0.
